pc_fetch_unit: RTL

- Program-counter and next-PC stage of the pipelined MIPS core.
- Consumes the ID-stage branch decision from the branch comparator, plus jump/JR requests. Drives the instruction-memory fetch address and the IF/ID flush.
- Holds the PC under hazard stalls and instruction-memory wait states. Buffers a redirect that arrives while memory is busy.

---
 rtl/pc_fetch_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter / next-PC stage of the pipelined MIPS core.
// Chooses the next fetch address from the ID-stage redirect requests
// (JR > J/JAL > taken branch > sequential). It holds the PC under hazard
// stalls and instruction-memory wait states. A redirect that arrives while
// memory is busy is parked in a one-entry pending slot, and the newest
// request replaces any older one.
//
// Build option:
//   DELAY_SLOT_EN  - when defined, the MIPS branch delay slot is honoured:
//                    flush_ifid stays 0 and the instruction in IF completes.
//                    Redirect timing and pending handling do not change.
//                    When undefined, flush_ifid pulses for one cycle per
//                    applied redirect and squashes the wrong-path instruction.
//
// Parameters:
//   RESET_PC      fetch address after reset
//   CNT_W         width of the taken-redirect counter
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   stall         hazard hold: PC frozen, redirects ignored
//   branch_ok     branch-taken decision for the instruction in ID
//   id_pc         PC of the instruction in ID
//   id_imm16      branch offset field of the ID instruction
//   jump          J/JAL in ID
//   jump_target   26-bit instr_index field
//   jr            JR/JALR in ID
//   jr_addr       forwarded register value for JR
//   imem_ready    instruction memory accepts/returns this cycle
//   pc            current fetch address
//   pc_plus4      pc + 4 (link value source), 32-bit wrap
//   if_valid      IF stage holds a real fetched instruction
//   flush_ifid    one-cycle squash of the IF/ID register
//   redirect_cnt  number of taken redirects since reset (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_ok,
    input  logic [31:0]      id_pc,
    input  logic [15:0]      id_imm16,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jr,
    input  logic [31:0]      jr_addr,
    input  logic             imem_ready,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             if_valid,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // In delay-slot mode the slot instruction always completes, so the
    // flush register is simply never loaded with a 1.
`ifdef DELAY_SLOT_EN
    localparam logic FLUSH_ON = 1'b0;
`else
    localparam logic FLUSH_ON = 1'b1;
`endif

    // Branch target: PC of the delay slot plus the word-scaled signed offset.
    function automatic logic [31:0] branch_tgt(input logic [31:0] base_pc,
                                               input logic [15:0] imm);
        logic [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return base_pc + 32'd4 + offset;
    endfunction

    // Jump target: the 256 MB region of the delay slot plus the word index.
    function automatic logic [31:0] jump_tgt(input logic [31:0] base_pc,
                                             input logic [25:0] index);
        return ((base_pc + 32'd4) & 32'hF000_0000) | {4'b0000, index, 2'b00};
    endfunction

    // Register jump target: force word alignment.
    function automatic logic [31:0] jr_tgt(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        pc_r;
    logic [31:0]        pc_next_s;
    logic               pend_valid_r;
    logic               pend_valid_next_s;
    logic [31:0]        pend_target_r;
    logic [31:0]        pend_target_next_s;
    logic               flush_r;
    logic               flush_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;

    logic               redir_req_s;
    logic               redir_valid_s;
    logic [31:0]        redir_target_s;
    logic               eff_valid_s;
    logic [31:0]        eff_target_s;

    // Redirect selection: priority is jr > jump > branch; only live outside BOOT and stall.
    always_comb begin
        redir_target_s = 32'h0000_0000;
        if (jr) begin
            redir_target_s = jr_tgt(jr_addr);
        end else if (jump) begin
            redir_target_s = jump_tgt(id_pc, jump_target);
        end else begin
            redir_target_s = branch_tgt(id_pc, id_imm16);
        end
        redir_req_s   = jr | jump | branch_ok;
        redir_valid_s = redir_req_s & ~stall & (state_r != ST_BOOT);
        // A fresh redirect supersedes whatever is parked in the pending slot.
        eff_valid_s   = redir_valid_s | pend_valid_r;
        if (redir_valid_s) begin
            eff_target_s = redir_target_s;
        end else begin
            eff_target_s = pend_target_r;
        end
    end

    // Next-state and next-register logic for the fetch FSM.
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        pend_valid_next_s  = pend_valid_r;
        pend_target_next_s = pend_target_r;
        flush_next_s       = 1'b0;
        cnt_next_s         = cnt_r;
        case (state_r)
            ST_BOOT: begin
                // One idle cycle at RESET_PC before fetching starts.
                state_next_s = ST_RUN;
            end
            ST_RUN, ST_WAIT: begin
                // Memory handshake alone decides RUN vs WAIT; a stall only
                // freezes the PC, the pending slot and the counter.
                if (imem_ready) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_WAIT;
                end
                if (!stall) begin
                    if (redir_valid_s) begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                    if (imem_ready) begin
                        pend_valid_next_s = 1'b0;
                        if (eff_valid_s) begin
                            pc_next_s    = eff_target_s;
                            flush_next_s = FLUSH_ON;
                        end else begin
                            pc_next_s    = pc_r + 32'd4;
                        end
                    end else begin
                        // Memory busy: park the newest redirect, hold the PC.
                        pend_valid_next_s  = eff_valid_s;
                        pend_target_next_s = eff_target_s;
                    end
                end else begin
                    flush_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_PC;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
            flush_r       <= 1'b0;
            cnt_r         <= '0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            pend_valid_r  <= pend_valid_next_s;
            pend_target_r <= pend_target_next_s;
            flush_r       <= flush_next_s;
            cnt_r         <= cnt_next_s;
        end
    end

    assign pc           = pc_r;
    assign pc_plus4     = pc_r + 32'd4;
    // The fetch at pc completes in any RUN cycle where memory answers.
    assign if_valid     = (state_r == ST_RUN) & imem_ready;
    assign flush_ifid   = flush_r;
    assign redirect_cnt = cnt_r;

endmodule
